depilot: RTL

DEPILOT -- requirements
Module: depilot

---
 rtl/depilot.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/depilot.sv
// Pilot-aided frame aligner: locks onto PILOT_LEN-symbol pilot runs, then forwards
// the DATA_LEN data symbols of each frame and drops lock when a frame's pilots are too corrupted.
module depilot #(
    parameter int                WIDTH      = 16,
    parameter int                PILOT_LEN  = 10,
    parameter int                DATA_LEN   = 400,
    parameter logic [WIDTH-1:0]  PILOT_WORD = 16'h7000,
    parameter int                MAX_ERR    = 3
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             locked,
    output logic             lost_sync,
    output logic [7:0]       bad_frames
);

    localparam int RUN_W = $clog2(PILOT_LEN + 1);
    localparam int PIL_W = (PILOT_LEN > 1) ? $clog2(PILOT_LEN) : 1;
    localparam int SYM_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam int ERR_W = $clog2(PILOT_LEN + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PILOT_LEN - 1);
    localparam logic [PIL_W-1:0] PIL_LAST = PIL_W'(PILOT_LEN - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(DATA_LEN - 1);

    typedef enum logic [1:0] {SEARCH, PILOT, DATA} state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [PIL_W-1:0]   pil_cnt_q, pil_cnt_d;
    logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_end_q, frame_end_d;
    logic               locked_q, locked_d;
    logic               lost_sync_q, lost_sync_d;
    logic [7:0]         bad_frames_q, bad_frames_d;
    logic               mismatch;
    logic [ERR_W-1:0]   err_next;

    // Pulses default low every cycle; everything else only moves on accepted symbols.
    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        pil_cnt_d     = pil_cnt_q;
        sym_cnt_d     = sym_cnt_q;
        err_cnt_d     = err_cnt_q;
        data_out_d    = data_out_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        locked_d      = locked_q;
        lost_sync_d   = 1'b0;
        bad_frames_d  = bad_frames_q;
        mismatch      = (data_in != PILOT_WORD);
        err_next      = err_cnt_q + ERR_W'(mismatch);

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (mismatch) begin
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d   = DATA;
                        run_d     = '0;
                        sym_cnt_d = '0;
                        locked_d  = 1'b1;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                DATA: begin
                    data_out_d    = data_in;
                    out_valid_d   = 1'b1;
                    frame_start_d = (sym_cnt_q == '0);
                    frame_end_d   = (sym_cnt_q == SYM_LAST);
                    if (sym_cnt_q == SYM_LAST) begin
                        state_d   = PILOT;
                        pil_cnt_d = '0;
                        err_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + SYM_W'(1);
                    end
                end
                PILOT: begin
                    // The final pilot's own mismatch counts toward the verdict.
                    if (pil_cnt_q == PIL_LAST) begin
                        pil_cnt_d = '0;
                        err_cnt_d = '0;
                        if (int'(err_next) > MAX_ERR) begin
                            state_d     = SEARCH;
                            run_d       = '0;
                            locked_d    = 1'b0;
                            lost_sync_d = 1'b1;
                            if (bad_frames_q != 8'hFF) begin
                                bad_frames_d = bad_frames_q + 8'd1;
                            end
                        end else begin
                            state_d   = DATA;
                            sym_cnt_d = '0;
                        end
                    end else begin
                        pil_cnt_d = pil_cnt_q + PIL_W'(1);
                        err_cnt_d = err_next;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            run_q         <= '0;
            pil_cnt_q     <= '0;
            sym_cnt_q     <= '0;
            err_cnt_q     <= '0;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            locked_q      <= 1'b0;
            lost_sync_q   <= 1'b0;
            bad_frames_q  <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            pil_cnt_q     <= pil_cnt_d;
            sym_cnt_q     <= sym_cnt_d;
            err_cnt_q     <= err_cnt_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            locked_q      <= locked_d;
            lost_sync_q   <= lost_sync_d;
            bad_frames_q  <= bad_frames_d;
        end
    end

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign locked      = locked_q;
    assign lost_sync   = lost_sync_q;
    assign bad_frames  = bad_frames_q;

endmodule
